pe_feeder: RTL
==============

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter DATA_W, default 16: width of image and weight values.
REQ-002 Parameter S_MAX, default 8: filter-tap buffer depth.
REQ-003 Parameter W_MAX, default 32: image-row buffer depth.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wt_wr_en / wt_wr_addr / wt_wr_data  in  1 / clog2(S_MAX) / DATA_W  filter-tap write port.
REQ-007 img_wr_en / img_wr_addr / img_wr_data  in  1 / clog2(W_MAX) / DATA_W  image-row write port.
REQ-008 cfg_s  in  clog2(S_MAX)+1  filter length S; cfg_w  in  clog2(W_MAX)+1  image length W.
REQ-009 start  in  1  begin a 1-D convolution pass; hold  in  1  freeze the sequence.
REQ-010 image_val / image_en  out  DATA_W / 1  activation beat to the PE.
REQ-011 weight_val / weight_en  out  DATA_W / 1  weight beat to the PE.
REQ-012 psum_clear  out  1  high on tap 0 of each window (chain psum_in forced to 0).
REQ-013 window_last  out  1  high on tap S-1 of each window (result valid at PE output on the next cycle).
REQ-014 busy  out  1; done  out  1; cfg_err  out  1.

Function
REQ-015 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: buffer writes accepted; a write to an address >= depth is dropped.
REQ-017 IDLE + start with 1<=S<=W, S<=S_MAX, W<=W_MAX: latch S and W; clear o and s; next state RUN.
REQ-018 IDLE + start with invalid cfg: stay IDLE; cfg_err pulses for exactly 1 cycle.
REQ-019 RUN: E=W-S+1 windows; each cycle without hold emits image_val=img[o+s], weight_val=wt[s], and image_en=weight_en=1.
REQ-020 Order: s increments 0..S-1 within a window; at s=S-1, s wraps to 0 and o increments; total E*S beats.
REQ-021 First beat appears in the cycle after start is sampled; beats are back-to-back absent hold.
REQ-022 hold=1 in RUN: image_en=weight_en=psum_clear=window_last=0; o and s frozen; stream resumes exactly where it stopped.
REQ-023 After the last beat (o=E-1, s=S-1): enter DONE; done=1 for one cycle; then IDLE.
REQ-024 busy=1 in RUN and DONE; busy=0 in IDLE.
REQ-025 Buffer writes and start are ignored while busy=1.
REQ-026 When enables are low, image_val and weight_val hold their last values.

Reset
REQ-027 rst=1 at a clock edge: state IDLE; o=s=0; image_en, weight_en, psum_clear, window_last, busy, done and cfg_err all 0; image_val=weight_val=0.
REQ-028 Reset mid-RUN aborts the pass immediately with no done pulse.
REQ-029 Buffer contents are not cleared by reset.

Configuration
REQ-030 Macro FEEDER_ZERO_SKIP_EN defined: a RUN beat with img[o+s]==0 drives image_en=0 and weight_en=1; timing, counters, psum_clear and window_last are unchanged, so the PE forwards psum.
REQ-031 Macro FEEDER_ZERO_SKIP_EN undefined: image_en=1 on every RUN beat regardless of value.

Verification
REQ-032 Load wt={1,2,3}, img={1,2,3,4,5}; S=3, W=5; start -> 9 beats; window pairs (1,1)(2,2)(3,3) / (2,1)(3,2)(4,3) / (3,1)(4,2)(5,3); psum_clear on beats 1,4,7; window_last on beats 3,6,9; done on cycle 10 after start.
REQ-033 Same load; hold=1 for 2 cycles after beat 4 -> no enables during hold; beat 5 is (3,2); 9 beats total; done delayed by 2 cycles.
REQ-034 S=4, W=3, start -> busy stays 0, cfg_err pulses one cycle, no beats; S=0 behaves the same.
REQ-035 rst asserted after beat 5 -> next cycle all outputs 0, busy=0, no done; new start replays from beat 1 with buffers intact.
REQ-036 img[2]=0 with FEEDER_ZERO_SKIP_EN defined -> beats carrying img[2] show image_en=0, weight_en=1; without the macro, image_en=1 on those beats.

Source files
------------

// File: rtl/pe_feeder_if.sv
// pe_feeder_if: buffer-write, config/control and PE beat signals of the feeder.
interface pe_feeder_if #(
    parameter int DATA_W = 16,
    parameter int S_MAX  = 8,
    parameter int W_MAX  = 32
);
    localparam int SA = $clog2(S_MAX);
    localparam int IA = $clog2(W_MAX);
    logic              wt_wr_en;
    logic [SA-1:0]     wt_wr_addr;
    logic [DATA_W-1:0] wt_wr_data;
    logic              img_wr_en;
    logic [IA-1:0]     img_wr_addr;
    logic [DATA_W-1:0] img_wr_data;
    logic [SA:0]       cfg_s;
    logic [IA:0]       cfg_w;
    logic              start;
    logic              hold;
    logic [DATA_W-1:0] image_val;
    logic              image_en;
    logic [DATA_W-1:0] weight_val;
    logic              weight_en;
    logic              psum_clear;
    logic              window_last;
    logic              busy;
    logic              done;
    logic              cfg_err;
    modport master (
        output wt_wr_en, wt_wr_addr, wt_wr_data, img_wr_en, img_wr_addr, img_wr_data,
        output cfg_s, cfg_w, start, hold,
        input  image_val, image_en, weight_val, weight_en, psum_clear, window_last,
        input  busy, done, cfg_err
    );
    modport slave (
        input  wt_wr_en, wt_wr_addr, wt_wr_data, img_wr_en, img_wr_addr, img_wr_data,
        input  cfg_s, cfg_w, start, hold,
        output image_val, image_en, weight_val, weight_en, psum_clear, window_last,
        output busy, done, cfg_err
    );
endinterface

// File: rtl/pe_feeder.sv
// pe_feeder: streams 1-D convolution (image, weight) beats from tap/row buffers to a PE.
// FEEDER_ZERO_SKIP_EN: zero image values drop image_en so the PE forwards psum.
module pe_feeder #(
    parameter int DATA_W = 16,
    parameter int S_MAX  = 8,
    parameter int W_MAX  = 32
) (
    input logic        clk,
    input logic        rst,
    pe_feeder_if.slave bus
);
    localparam int SA = $clog2(S_MAX);
    localparam int IA = $clog2(W_MAX);
    localparam int CW = (SA > IA ? SA : IA) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            st;
    logic [DATA_W-1:0] wt  [S_MAX];
    logic [DATA_W-1:0] img [W_MAX];
    logic [CW-1:0]     o, s, sl, wl;
    logic [CW-1:0]     ns, nw, bo, bs, ls, lw;
    logic [IA-1:0]     idx;
    logic [DATA_W-1:0] iv, wv;
    logic              fin, cfg_ok, go, s_last, e_last, nz;
    // In IDLE the beat emitted on start is (0,0) of the incoming config.
    always_comb begin
        ns     = CW'(bus.cfg_s);
        nw     = CW'(bus.cfg_w);
        cfg_ok = ns != '0 && ns <= nw && ns <= CW'(S_MAX) && nw <= CW'(W_MAX);
        bo     = st == RUN ? o : '0;
        bs     = st == RUN ? s : '0;
        ls     = st == RUN ? sl : ns;
        lw     = st == RUN ? wl : nw;
        s_last = bs == ls - 1'b1;
        e_last = bo == lw - ls;
        idx    = IA'(bo + bs);
        iv     = img[idx];
        wv     = wt[bs[SA-1:0]];
`ifdef FEEDER_ZERO_SKIP_EN
        nz     = iv != '0;
`else
        nz     = 1'b1;
`endif
        go     = (st == IDLE && bus.start && cfg_ok) || (st == RUN && !bus.hold && !fin);
    end
    always_ff @(posedge clk) begin
        if (st == IDLE && bus.wt_wr_en && {1'b0, bus.wt_wr_addr} < (SA+1)'(S_MAX))
            wt[bus.wt_wr_addr] <= bus.wt_wr_data;
        if (st == IDLE && bus.img_wr_en && {1'b0, bus.img_wr_addr} < (IA+1)'(W_MAX))
            img[bus.img_wr_addr] <= bus.img_wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st              <= IDLE;
            o               <= '0;
            s               <= '0;
            sl              <= '0;
            wl              <= '0;
            fin             <= 1'b0;
            bus.image_val   <= '0;
            bus.weight_val  <= '0;
            bus.image_en    <= 1'b0;
            bus.weight_en   <= 1'b0;
            bus.psum_clear  <= 1'b0;
            bus.window_last <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.cfg_err     <= 1'b0;
        end else begin
            bus.image_en    <= 1'b0;
            bus.weight_en   <= 1'b0;
            bus.psum_clear  <= 1'b0;
            bus.window_last <= 1'b0;
            bus.done        <= 1'b0;
            bus.cfg_err     <= 1'b0;
            case (st)
                IDLE: begin
                    bus.cfg_err <= bus.start && !cfg_ok;
                    if (bus.start && cfg_ok) begin
                        st       <= RUN;
                        bus.busy <= 1'b1;
                        sl       <= ns;
                        wl       <= nw;
                    end
                end
                RUN: if (!bus.hold && fin) begin
                    st       <= DONE;
                    bus.done <= 1'b1;
                end
                DONE: begin
                    st       <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: st <= IDLE;
            endcase
            if (go) begin
                if (nz) bus.image_val <= iv;
                bus.image_en    <= nz;
                bus.weight_val  <= wv;
                bus.weight_en   <= 1'b1;
                bus.psum_clear  <= bs == '0;
                bus.window_last <= s_last;
                s               <= s_last ? '0 : bs + 1'b1;
                o               <= s_last ? bo + 1'b1 : bo;
                fin             <= s_last && e_last;
            end
        end
    end
endmodule
